axi_lite_mem_arbiter: RTL
=========================

Name: axi_lite_mem_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch AXI4-Lite master (read-only) and its data AXI4-Lite master (read/write).
- Sits between the datapath and the memory model, or the DRAM/peripheral bus.
- Arbitrates requests, holds at most one transaction in flight, and sequences the memory strobes.
- Returns read data and write responses to the owning master with AXI4-Lite handshakes.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; DATA_W/8 strobe/mask bits
FAIR, 1, 1 = round-robin between inst and data masters; 0 = data master always wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_araddr  in  ADDR_W  inst read address
i_arvalid  in  1  inst read request
i_arready  out  1  inst address accepted
i_rdata  out  DATA_W  inst read data
i_rvalid  out  1  inst read data valid
i_rready  in  1  inst master accepts data
d_araddr  in  ADDR_W  data read address
d_arvalid  in  1  data read request
d_arready  out  1  data read address accepted
d_rdata  out  DATA_W  data read data
d_rvalid  out  1  data read data valid
d_rready  in  1  data master accepts read data
d_awaddr  in  ADDR_W  write address
d_awvalid  in  1  write address valid
d_awready  out  1  write address accepted
d_wdata  in  DATA_W  write data
d_wstrb  in  DATA_W/8  byte strobes
d_wvalid  in  1  write data valid
d_wready  out  1  write data accepted
d_bvalid  out  1  write response valid
d_bready  in  1  master accepts write response
i_rresp, d_rresp, d_bresp  out  2 each  constant 2'b00 (OKAY)
mem_raddr  out  ADDR_W  memory read address
mem_ren  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid this cycle (variable latency, may equal ren cycle)
mem_waddr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  byte write mask (= latched d_wstrb)
mem_wen  out  1  memory write strobe

Behaviour:
- States: IDLE, RD, RRESP, WR, BRESP. Registers: owner (INST/DATA), last_data, addr, wdata, wmask, rdata.
- Reset: state=IDLE, owner=INST, last_data=0, every valid/ready/strobe output 0, data/address outputs 0. Reset mid-transaction aborts it; no response is ever issued for the aborted transaction.
- IDLE candidates:
  - Write: d_awvalid && d_wvalid both high. AW or W alone is not a candidate.
  - Data read: d_arvalid.
  - Inst read: i_arvalid.
- Data-side order: write before read.
- Inst vs data:
  - FAIR=1 and both sides requesting: grant the side not granted last (inst when last_data=1).
  - FAIR=0: data always wins.
- Grant happens in IDLE, in the same cycle. The winner's ready is combinationally high: i_arready, d_arready, or d_awready with d_wready together. Address, data and strobes are latched. last_data is updated. At most one ready is high per cycle, and only in IDLE.
- RD: mem_ren=1, mem_raddr=latched addr, held until mem_rvalid. mem_rdata is captured on mem_rvalid. Next state RRESP.
- RRESP: owner's rvalid=1 with the captured rdata, held stable until rready. The cycle with rvalid && rready returns to IDLE; a new grant is possible in that IDLE cycle at the earliest.
- WR: mem_wen=1 for exactly one cycle with the latched waddr/wdata/wmask. Next state BRESP.
- BRESP: d_bvalid=1 until d_bready, then IDLE.
- Outside RD, mem_ren=0; outside WR, mem_wen=0.
- Minimum latency with mem_rvalid in the ren cycle and rready tied high: arvalid at cycle 0, rvalid at cycle 2; next grant at cycle 3. Write: grant at 0, wen at 1, bvalid at 2.
- A request that loses arbitration keeps its valid asserted (AXI rule) and is granted once it wins.

Test Plan:
- Inst read 0x8000_0000 alone, mem returns 0x0000_0013 in the ren cycle -> i_arready at cycle 0, mem_ren at cycle 1, i_rvalid with i_rdata=0x13 at cycle 2, i_rresp=0.
- Data write addr 0x100, wdata 0xDEADBEEF, wstrb 4'b0011 -> awready and wready at cycle 0, single-cycle mem_wen at cycle 1 with mem_wmask=0011, d_bvalid at cycle 2 held until bready.
- i_arvalid and d_arvalid held continuously, FAIR=1 -> grants alternate data, inst, data, inst; with FAIR=0 only data is granted.
- d_awvalid high without d_wvalid for 3 cycles while i_arvalid is high -> inst is granted and no write occurs; write is granted only once d_wvalid is also high.
- mem_rvalid delayed 4 cycles and rready held low 2 cycles -> mem_ren stays high for 4 cycles; rvalid/rdata stay stable; no other ready is asserted meanwhile.
- rst asserted while in RD -> next cycle all outputs are 0 and state is IDLE; no stale rvalid appears after rst drops.

Source files
------------

// File: rtl/axi_lite_mem_arbiter.sv
// Two AXI4-Lite masters (inst fetch, read-only; data, read/write) share one single-ported memory.
// One transaction in flight; grant is made combinationally in IDLE, everything else comes from registered state.
module axi_lite_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                i_rready,
  output logic [1:0]          i_rresp,
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [1:0]          d_rresp,
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic                d_wvalid,
  output logic                d_wready,
  output logic                d_bvalid,
  input  logic                d_bready,
  output logic [1:0]          d_bresp,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic                mem_ren,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_wen
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD, RRESP, WR, BRESP} state_t;

  state_t              state_q;
  logic                owner_q;      // 0 = inst, 1 = data
  logic                last_data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wmask_q;
  logic [DATA_W-1:0]   rdata_q;

  logic wr_cand, d_cand, i_cand, data_wins;
  logic grant_data, grant_inst, grant_wr, grant_drd;

  // A write needs both AW and W present; data side prefers write over read.
  always_comb begin
    wr_cand    = d_awvalid && d_wvalid;
    d_cand     = wr_cand || d_arvalid;
    i_cand     = i_arvalid;
    data_wins  = (FAIR == 0) || !i_cand || !last_data_q;
    grant_data = (state_q == IDLE) && d_cand && data_wins;
    grant_inst = (state_q == IDLE) && i_cand && !grant_data;
    grant_wr   = grant_data && wr_cand;
    grant_drd  = grant_data && !wr_cand;
  end

  assign i_arready = grant_inst;
  assign d_arready = grant_drd;
  assign d_awready = grant_wr;
  assign d_wready  = grant_wr;

  assign i_rvalid  = (state_q == RRESP) && !owner_q;
  assign d_rvalid  = (state_q == RRESP) && owner_q;
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign d_bvalid  = (state_q == BRESP);
  assign i_rresp   = 2'b00;
  assign d_rresp   = 2'b00;
  assign d_bresp   = 2'b00;

  assign mem_ren   = (state_q == RD);
  assign mem_raddr = addr_q;
  assign mem_wen   = (state_q == WR);
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_inst) begin
            owner_q     <= 1'b0;
            last_data_q <= 1'b0;
            addr_q      <= i_araddr;
            state_q     <= RD;
          end else if (grant_drd) begin
            owner_q     <= 1'b1;
            last_data_q <= 1'b1;
            addr_q      <= d_araddr;
            state_q     <= RD;
          end else if (grant_wr) begin
            owner_q     <= 1'b1;
            last_data_q <= 1'b1;
            addr_q      <= d_awaddr;
            wdata_q     <= d_wdata;
            wmask_q     <= d_wstrb;
            state_q     <= WR;
          end
        end
        RD: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= RRESP;
          end
        end
        RRESP: begin
          if (owner_q ? d_rready : i_rready) state_q <= IDLE;
        end
        WR:      state_q <= BRESP;
        BRESP: begin
          if (d_bready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
